vga_mem_arbiter: RTL and testbench
==================================

# vga_mem_arbiter

Single-port framebuffer memory arbiter in the `mem_clk_in` domain, between the VGA controller's line-prefetch logic and a pixel-write port. It grants one requester at a time, sequences fixed-length read bursts for display fetch and single-word writes, and returns read data tagged with valid/last strobes. It alternates grants under contention so neither side starves.

## Interface
- `ADDR_W`, default 17: framebuffer word-address width.
- `DATA_W`, default 12: pixel word width (4:4:4 RGB).
- `BURST`, default 8: reads per fetch grant, ≥2.
- `RD_LAT`, default 2: memory read latency in cycles, ≥1.

Ports:
- `mem_clk_in`  in  1: sole clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `fetch_req`  in  1: display fetch request, level, held until `fetch_ack`.
- `fetch_addr`  in  ADDR_W: burst start address, sampled at grant.
- `fetch_ack`  out  1: one-cycle grant pulse.
- `fetch_data`  out  DATA_W: read data, equals `mem_rdata`.
- `fetch_valid`  out  1: `fetch_data` valid this cycle.
- `fetch_done`  out  1: coincident with the last `fetch_valid` of a burst.
- `wr_req`  in  1: write request, level, held until `wr_ack`.
- `wr_addr`  in  ADDR_W: write address, sampled at grant.
- `wr_data`  in  DATA_W: write data, sampled at grant.
- `wr_ack`  out  1: one-cycle grant pulse.
- `mem_en`  out  1: memory access strobe.
- `mem_we`  out  1: 1 = write, 0 = read. Meaningful only with `mem_en`.
- `mem_addr`  out  ADDR_W: memory address.
- `mem_wdata`  out  DATA_W: memory write data.
- `mem_rdata`  in  DATA_W: memory read data, `RD_LAT` cycles after a read strobe.
- `busy`  out  1: state ≠ IDLE or any read still in flight.

## Operation
- FSM states: IDLE, BURST, WRITE. All outputs except `fetch_data` are registered.
- **IDLE arbitration:**
  - Only `fetch_req` high: go to BURST.
  - Only `wr_req` high: go to WRITE.
  - Both high: grant the requester not in `last_grant`. Update `last_grant` on every grant.
- **Fetch grant edge:**
  - `addr <= fetch_addr`, `cnt <= 0`, state to BURST.
  - `fetch_ack` is high for the following cycle only.
- **BURST, each cycle:**
  - `mem_en` = 1, `mem_we` = 0, `mem_addr` = `addr`.
  - `addr` increments modulo 2^ADDR_W; wraps from all-ones to 0.
  - At `cnt` = BURST−1, return to IDLE.
- **Write grant edge:**
  - Latch `wr_addr` and `wr_data`, state to WRITE.
  - `wr_ack` is high for the following cycle only.
- **WRITE:** one cycle with `mem_en` = 1, `mem_we` = 1, latched address and data; then IDLE.
- **Turnaround:** exactly one IDLE cycle (`mem_en` = 0) separates consecutive transactions.
- **Read return:**
  - A RD_LAT-deep shift register carries (valid, last) per read strobe.
  - `fetch_valid` / `fetch_done` come from its output stage.
  - Reads still in flight do not block new grants; return order is preserved.
- **Request withdrawal:** a request dropped before its ack is never granted, and nothing is issued for it.
- **Reset:**
  - State IDLE, `last_grant` = WRITE (fetch wins the first conflict).
  - `addr`, `cnt`, shift register cleared.
  - `fetch_ack`, `wr_ack`, `fetch_valid`, `fetch_done`, `mem_en`, `mem_we`, `busy` = 0; `mem_addr`, `mem_wdata` = 0.
  - Reset mid-burst aborts the remaining reads. Data returning after reset is ignored: no `fetch_valid`, no `fetch_done`.

## Timing
- **Fetch**, request seen in IDLE cycle c:
  - `fetch_ack` and first `mem_en` in c+1.
  - Last read strobe in c+BURST.
  - First `fetch_valid` in c+1+RD_LAT; `fetch_done` in c+BURST+RD_LAT.
- **Write**, request seen in IDLE cycle c: `wr_ack` and the write strobe in c+1.
- **Next grant:** earliest evaluation in the IDLE cycle after the transaction's last strobe.
- **Back-to-back fetches:** a new burst's first strobe is ≥2 cycles after the previous last strobe. Valids for the two bursts may be separated by one idle cycle.
- **Requests arriving mid-transaction:** held and evaluated in the next IDLE cycle.

## Test plan
- **Single fetch:** reset, then `fetch_req` with `fetch_addr` = 0x00100, BURST = 8, RD_LAT = 2.
  - `mem_addr` 0x00100..0x00107 in cycles 1–8; 8 `fetch_valid` in cycles 3–10.
  - `fetch_done` only in cycle 10.
- **Address wrap:** `fetch_addr` = 0x1FFFE → `mem_addr` sequence 0x1FFFE, 0x1FFFF, 0x00000 … 0x00005.
- **Contention:** `fetch_req` and `wr_req` held together from reset.
  - Grants alternate fetch, write, fetch, write.
  - Each write strobe has `mem_we` = 1 with the sampled `wr_addr` / `wr_data`.
- **Write during burst:** `wr_req` raised in burst cycle 3 → no write strobe until after the burst. `wr_ack` arrives in the cycle after the first IDLE cycle.
- **Reset mid-burst:** `rst` at burst cycle 4.
  - Next cycle: all outputs 0, state IDLE.
  - No `fetch_valid` follows despite `mem_rdata` activity.
- **Withdrawn request:** `wr_req` pulsed one cycle while BURST is active → no `wr_ack`, no write strobe.

Source files
------------

// File: rtl/vga_mem_arbiter_if.sv
// vga_mem_arbiter_if: request, read-return and memory-port bundle.
// slave = arbiter view, master = client/memory view.
interface vga_mem_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12
);
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ack;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_valid;
  logic              fetch_done;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  fetch_req, fetch_addr,
    input  wr_req, wr_addr, wr_data,
    input  mem_rdata,
    output fetch_ack, fetch_data,
    output fetch_valid, fetch_done,
    output wr_ack,
    output mem_en, mem_we,
    output mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output fetch_req, fetch_addr,
    output wr_req, wr_addr, wr_data,
    output mem_rdata,
    input  fetch_ack, fetch_data,
    input  fetch_valid, fetch_done,
    input  wr_ack,
    input  mem_en, mem_we,
    input  mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: single-port framebuffer arbiter, display fetch
// bursts vs pixel writes, alternating grants under contention.
// Ports: mem_clk_in (clock), rst (sync, active high),
//   bus (slave): fetch_* burst port, wr_* write port, mem_* memory
//   port, busy. fetch_data is mem_rdata; all else is registered.
module vga_mem_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12,
  parameter int BURST  = 8,
  parameter int RD_LAT = 2
) (
  input  logic mem_clk_in,
  input  logic rst,
  vga_mem_arbiter_if.slave bus
);
  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_WRITE
  } state_t;

  state_t            r_state;
  // next burst address to strobe
  logic [ADDR_W-1:0] r_addr;
  logic [CW-1:0]     r_cnt;
  logic              r_last_wr;
  // per-strobe (valid, last) travelling alongside the read latency
  logic [RD_LAT-1:0] r_vp;
  logic [RD_LAT-1:0] r_lp;

  logic              r_fetch_ack;
  logic              r_fetch_valid;
  logic              r_fetch_done;
  logic              r_wr_ack;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_busy;

  logic              w_gnt_f;
  logic              w_gnt_w;
  logic              w_in_burst;
  logic              w_bend;
  logic              w_rd_issue;
  logic              w_rd_last;
  logic              w_nxt_active;
  logic [RD_LAT-1:0] w_vp_nxt;
  logic [RD_LAT-1:0] w_lp_nxt;

  // under contention the side that did not win last time goes
  always_comb begin
    w_gnt_f = 1'b0;
    w_gnt_w = 1'b0;
    if (r_state == S_IDLE) begin
      if (bus.fetch_req && (!bus.wr_req || r_last_wr))
        w_gnt_f = 1'b1;
      else if (bus.wr_req)
        w_gnt_w = 1'b1;
    end
  end

  assign w_in_burst = (r_state == S_BURST);
  assign w_bend     = w_in_burst &&
                      (r_cnt == CW'(BURST - 1));
  // a read strobe is issued next cycle on grant or mid-burst
  assign w_rd_issue = w_gnt_f || (w_in_burst && !w_bend);
  assign w_rd_last  = w_in_burst &&
                      (r_cnt == CW'(BURST - 2));
  assign w_nxt_active = w_gnt_f || w_gnt_w ||
                        (w_in_burst && !w_bend);

  always_comb begin
    w_vp_nxt    = '0;
    w_lp_nxt    = '0;
    w_vp_nxt[0] = w_rd_issue;
    w_lp_nxt[0] = w_rd_last;
    for (int i = 1; i < RD_LAT; i++) begin
      w_vp_nxt[i] = r_vp[i-1];
      w_lp_nxt[i] = r_lp[i-1];
    end
  end

  always_ff @(posedge mem_clk_in) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_cnt         <= '0;
      r_last_wr     <= 1'b1;
      r_vp          <= '0;
      r_lp          <= '0;
      r_fetch_ack   <= 1'b0;
      r_fetch_valid <= 1'b0;
      r_fetch_done  <= 1'b0;
      r_wr_ack      <= 1'b0;
      r_mem_en      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_fetch_ack   <= 1'b0;
      r_wr_ack      <= 1'b0;
      r_vp          <= w_vp_nxt;
      r_lp          <= w_lp_nxt;
      r_fetch_valid <= r_vp[RD_LAT-1];
      r_fetch_done  <= r_vp[RD_LAT-1] &
                       r_lp[RD_LAT-1];
      r_busy        <= w_nxt_active | (|w_vp_nxt);
      unique case (r_state)
        S_IDLE: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
          if (w_gnt_f) begin
            r_state     <= S_BURST;
            r_mem_en    <= 1'b1;
            r_mem_addr  <= bus.fetch_addr;
            r_addr      <= bus.fetch_addr + ADDR_W'(1);
            r_cnt       <= '0;
            r_fetch_ack <= 1'b1;
            r_last_wr   <= 1'b0;
          end else if (w_gnt_w) begin
            r_state     <= S_WRITE;
            r_mem_en    <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= bus.wr_addr;
            r_mem_wdata <= bus.wr_data;
            r_wr_ack    <= 1'b1;
            r_last_wr   <= 1'b1;
          end
        end
        S_BURST: begin
          if (w_bend) begin
            r_state  <= S_IDLE;
            r_mem_en <= 1'b0;
          end else begin
            r_mem_en   <= 1'b1;
            r_mem_addr <= r_addr;
            r_addr     <= r_addr + ADDR_W'(1);
            r_cnt      <= r_cnt + CW'(1);
          end
        end
        S_WRITE: begin
          r_state  <= S_IDLE;
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fetch_ack   = r_fetch_ack;
  assign bus.fetch_data  = bus.mem_rdata;
  assign bus.fetch_valid = r_fetch_valid;
  assign bus.fetch_done  = r_fetch_done;
  assign bus.wr_ack      = r_wr_ack;
  assign bus.mem_en      = r_mem_en;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb_vga_mem_arbiter: directed + random requests against a
// transaction-level schedule model of grants, strobes and returns.
module tb_vga_mem_arbiter;
  localparam int AW     = 17;
  localparam int DW     = 12;
  localparam int BURST  = 8;
  localparam int RD_LAT = 2;
  localparam int NCYC   = 3000;
  localparam int NE     = NCYC + 32;

  logic mem_clk_in = 1'b0;
  logic rst = 1'b1;
  always #5 mem_clk_in = ~mem_clk_in;

  vga_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  vga_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW),
    .BURST(BURST), .RD_LAT(RD_LAT)
  ) dut (
    .mem_clk_in(mem_clk_in),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [DW-1:0] hsh(input logic [AW-1:0] a);
    logic [AW-1:0] x;
    x = a ^ (a >> 7) ^ 17'h0A5C3;
    return x[11:0] ^ {x[16:12], 7'b0};
  endfunction

  // memory: reads return hsh(addr) RD_LAT cycles after the strobe,
  // otherwise random noise on the data bus
  logic [DW-1:0] rq [RD_LAT];
  always @(posedge mem_clk_in) begin
    for (int i = RD_LAT - 1; i > 0; i--) rq[i] = rq[i-1];
    if (bus.mem_en === 1'b1 && bus.mem_we === 1'b0)
      rq[0] = hsh(bus.mem_addr);
    else
      rq[0] = DW'($urandom);
    bus.mem_rdata = rq[RD_LAT-1];
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cur     = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc %0d: got %0h expected %0h",
               tag, cur, got, exp);
    end
  endtask

  // expected per-cycle outputs
  bit          e_en    [NE];
  bit          e_we    [NE];
  logic [AW-1:0] e_addr [NE];
  logic [DW-1:0] e_wd   [NE];
  bit          e_fack  [NE];
  bit          e_wack  [NE];
  bit          e_fv    [NE];
  bit          e_fd    [NE];
  logic [DW-1:0] e_fdat [NE];
  bit          e_busy  [NE];
  bit          e_rchk  [NE];

  // requester / model state
  bit          f_pend = 0;
  bit          w_pend = 0;
  logic [AW-1:0] f_a = '0;
  logic [AW-1:0] w_a = '0;
  logic [DW-1:0] w_d = '0;
  bit          last_wr = 1;
  int          next_dec = 0;
  bit          arm_rst = 0;
  bit          arm_wd = 0;
  int          rst_at = -1;
  int          wd_at = -1;

  task automatic mreset(input int n);
    for (int t = n + 1; t < NE; t++) begin
      e_en[t] = 0; e_we[t] = 0; e_fack[t] = 0;
      e_wack[t] = 0; e_fv[t] = 0; e_fd[t] = 0;
      e_busy[t] = 0;
    end
    e_rchk[n+1] = 1;
    next_dec = n + 1;
    last_wr = 1;
  endtask

  task automatic decide(input int n);
    if (f_pend && (!w_pend || last_wr)) begin
      for (int i = 0; i < BURST; i++) begin
        int t;
        logic [AW-1:0] a;
        t = n + 1 + i;
        a = f_a + AW'(i);
        e_en[t] = 1;
        e_we[t] = 0;
        e_addr[t] = a;
        for (int k = 0; k < RD_LAT; k++) e_busy[t+k] = 1;
        e_fv[t+RD_LAT] = 1;
        e_fdat[t+RD_LAT] = hsh(a);
        e_fd[t+RD_LAT] = (i == BURST - 1);
      end
      e_fack[n+1] = 1;
      next_dec = n + BURST + 1;
      last_wr = 0;
      f_pend = 0;
      if (arm_rst) begin rst_at = n + 4; arm_rst = 0; end
      if (arm_wd) begin wd_at = n + 2; arm_wd = 0; end
    end else if (w_pend) begin
      e_en[n+1] = 1;
      e_we[n+1] = 1;
      e_addr[n+1] = w_a;
      e_wd[n+1] = w_d;
      e_busy[n+1] = 1;
      e_wack[n+1] = 1;
      next_dec = n + 2;
      last_wr = 1;
      w_pend = 0;
    end
  endtask

  task automatic check_cycle(input int n);
    cur = n;
    chk("mem_en", 32'(bus.mem_en), 32'(e_en[n]));
    chk("fetch_ack", 32'(bus.fetch_ack), 32'(e_fack[n]));
    chk("wr_ack", 32'(bus.wr_ack), 32'(e_wack[n]));
    chk("fetch_valid", 32'(bus.fetch_valid), 32'(e_fv[n]));
    chk("fetch_done", 32'(bus.fetch_done), 32'(e_fd[n]));
    chk("busy", 32'(bus.busy), 32'(e_busy[n]));
    if (e_en[n]) begin
      chk("mem_we", 32'(bus.mem_we), 32'(e_we[n]));
      chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr[n]));
      if (e_we[n])
        chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wd[n]));
    end
    if (e_fv[n])
      chk("fetch_data", 32'(bus.fetch_data), 32'(e_fdat[n]));
    if (e_rchk[n]) begin
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
      chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    end
  endtask

  task automatic rand_req();
    if (!f_pend) begin
      if ($urandom_range(3) == 0) begin
        f_pend = 1;
        if ($urandom_range(7) == 0)
          f_a = 17'h1FFF8 + AW'($urandom_range(7));
        else
          f_a = AW'($urandom);
      end
    end else if ($urandom_range(15) == 0) begin
      f_pend = 0;
    end
    if (!w_pend) begin
      if ($urandom_range(3) == 0) begin
        w_pend = 1;
        w_a = AW'($urandom);
        w_d = DW'($urandom);
      end
    end else if ($urandom_range(15) == 0) begin
      w_pend = 0;
    end
  endtask

  initial begin
    bus.fetch_req = 0;
    bus.fetch_addr = '0;
    bus.wr_req = 0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    for (int n = 1; n < NCYC; n++) begin
      @(negedge mem_clk_in);
      check_cycle(n);
      rst = (n < 3) || (n == 40) || (n == 41) || (n == rst_at);
      // single fetch, then a write raised in burst cycle 3
      if (n == 5) begin f_pend = 1; f_a = 17'h00100; end
      if (n == 8) begin
        w_pend = 1; w_a = 17'h0ABCD; w_d = 12'h5A5;
      end
      if (n == 20) begin f_pend = 1; f_a = 17'h1FFFE; end
      if (n == 32) begin
        w_pend = 1; w_a = 17'h1F00F; w_d = 12'hC3C;
      end
      // contention from reset
      if (n >= 40 && n <= 100) begin
        if (!f_pend) begin f_pend = 1; f_a = AW'($urandom); end
        if (!w_pend) begin
          w_pend = 1; w_a = AW'($urandom); w_d = DW'($urandom);
        end
      end
      if (n == 101) begin f_pend = 0; w_pend = 0; end
      if (n == 120) begin
        f_pend = 1; f_a = AW'($urandom); arm_rst = 1;
      end
      if (n == 150) begin
        f_pend = 1; f_a = AW'($urandom); arm_wd = 1;
      end
      if (n == wd_at) begin
        w_pend = 1; w_a = AW'($urandom); w_d = DW'($urandom);
      end
      if (wd_at > 0 && n == wd_at + 1) w_pend = 0;
      if (n >= 170 && n < NCYC - 60) begin
        rand_req();
        if ($urandom_range(149) == 0) rst = 1;
      end
      if (n == NCYC - 60) begin f_pend = 0; w_pend = 0; end
      bus.fetch_req = f_pend;
      bus.fetch_addr = f_a;
      bus.wr_req = w_pend;
      bus.wr_addr = w_a;
      bus.wr_data = w_d;
      if (rst) mreset(n);
      else if (n >= next_dec) decide(n);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
